// File: rtl/readout_arbiter.sv
// Round-robin merger of four FWFT readout FIFOs into one 33-bit output stream.
// Each grant emits an optional timestamp header and up to MAX_BURST data words.

module readout_arbiter_lane #(
  parameter logic [1:0] ID = 2'd0
) (
  input  logic        en,
  input  logic        empty,
  input  logic [29:0] data,
  output logic        elig,
  output logic [32:0] dword
);
  assign elig  = en & ~empty;
  assign dword = {1'b0, ID, data};
endmodule

module readout_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk40,
  input  logic        reset_n,
  input  logic [3:0]  enableChannel,
  input  logic        noTimestamp,
  input  logic [3:0]  ch_empty,
  input  logic [31:0] ch1_data,
  input  logic [31:0] ch2_data,
  input  logic [31:0] ch3_data,
  input  logic [31:0] ch4_data,
  output logic [3:0]  ch_rd_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [32:0] out_din,
  output logic [3:0]  grant,
  output logic        busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     last_q, last_d;
  logic [1:0]                     gid_q, gid_d;
  logic [29:0]                    ts_q, ts_d;
  logic [7:0]                     bcnt_q, bcnt_d;

  logic [NUM_LANES-1:0][29:0]     ch_data;
  logic [NUM_LANES-1:0]           elig;
  logic [NUM_LANES-1:0][32:0]     dword;
  logic                           found;
  logic [1:0]                     pick;
  logic [8:0]                     bnext;
  logic                           unused_hi;

  // Only the low 30 bits of each FIFO head carry payload.
  assign ch_data   = {ch4_data[29:0], ch3_data[29:0], ch2_data[29:0], ch1_data[29:0]};
  assign unused_hi = ^{ch4_data[31:30], ch3_data[31:30], ch2_data[31:30], ch1_data[31:30]};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      readout_arbiter_lane #(.ID(2'(i))) u_lane (
        .en    (enableChannel[i]),
        .empty (ch_empty[i]),
        .data  (ch_data[i]),
        .elig  (elig[i]),
        .dword (dword[i])
      );
    end
  endgenerate

  // Search upward from the channel after the last grant; k=4 wraps to last itself.
  always_comb begin : p_search
    logic [1:0] idx;
    found = 1'b0;
    pick  = last_q;
    idx   = last_q;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = last_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign bnext = {1'b0, bcnt_q} + 9'd1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gid_d     = gid_q;
    bcnt_d    = bcnt_q;
    ts_d      = ts_q + 30'd1;
    out_wr_en = 1'b0;
    ch_rd_en  = '0;
    out_din   = '0;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (found) begin
          gid_d   = pick;
          last_d  = pick;
          state_d = noTimestamp ? BURST : HDR;
        end
      end
      HDR: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          out_din   = {1'b1, gid_q, ts_q};
          state_d   = BURST;
        end
      end
      BURST: begin
        // Loss of eligibility ends the grant even while the output is full.
        if (!elig[gid_q]) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (!out_full) begin
          out_wr_en = 1'b1;
          ch_rd_en  = 4'b0001 << gid_q;
          out_din   = dword[gid_q];
          if (bnext >= 9'(MAX_BURST)) begin
            state_d = IDLE;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bnext[7:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      gid_q   <= 2'd0;
      ts_q    <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ts_q    <= ts_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? (4'b0001 << gid_q) : 4'b0000;

endmodule

// File: tb/tb_readout_arbiter.sv
// Directed bench for readout_arbiter: FIFO heads modelled as counters, output stream logged and
// compared against hand-built expected word lists.

module tb_readout_arbiter;
  logic        clk40 = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  enableChannel;
  logic        noTimestamp;
  logic [3:0]  ch_empty;
  logic [31:0] ch_data [4];
  logic [3:0]  ch_rd_en;
  logic        out_full;
  logic        out_wr_en;
  logic [32:0] out_din;
  logic [3:0]  grant;
  logic        busy;

  int          cnt [4];
  logic [29:0] head [4];
  int          vec, errs, tcnt;

  logic        s_wr, s_busy;
  logic [3:0]  s_rd, s_g;
  logic [32:0] s_din;

  typedef struct {logic hdr; logic [1:0] ch; logic [29:0] d;} exp_t;
  exp_t        eq [$];
  logic [32:0] lw [$];
  int          lts [$];
  logic [3:0]  lg [$];

  always #5 clk40 = ~clk40;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_empty[i] = (cnt[i] == 0);
      ch_data[i]  = {2'b11, head[i]};
    end
  end

  readout_arbiter #(.MAX_BURST(4)) dut (
    .clk40(clk40), .reset_n(reset_n), .enableChannel(enableChannel), .noTimestamp(noTimestamp),
    .ch_empty(ch_empty), .ch1_data(ch_data[0]), .ch2_data(ch_data[1]), .ch3_data(ch_data[2]),
    .ch4_data(ch_data[3]), .ch_rd_en(ch_rd_en), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_din(out_din), .grant(grant), .busy(busy)
  );

  // Sample outputs mid-cycle, log writes, then advance one clock and pop the FIFO model.
  task automatic cyc();
    #1;
    s_wr = out_wr_en; s_rd = ch_rd_en; s_din = out_din; s_g = grant; s_busy = busy;
    if (s_wr) begin lw.push_back(s_din); lts.push_back(tcnt); lg.push_back(s_g); end
    if (s_rd != 4'b0) begin
      vec++;
      if (!s_wr || !$onehot(s_rd) || ((s_rd & ch_empty) != 4'b0)) begin
        errs++;
        $display("FAIL rd_en_rule: rd=%b wr=%b empty=%b (need one-hot, with write, non-empty)", s_rd, s_wr, ch_empty);
      end
    end
    @(posedge clk40);
    if (reset_n) tcnt++;
    #1;
    for (int i = 0; i < 4; i++)
      if (s_rd[i]) begin cnt[i] = cnt[i] - 1; head[i] = head[i] + 30'd1; end
  endtask

  task automatic load(input int ch, input int n, input logic [29:0] base);
    cnt[ch] = n; head[ch] = base;
  endtask

  task automatic ex(input logic h, input logic [1:0] c, input logic [29:0] d);
    exp_t e;
    e.hdr = h; e.ch = c; e.d = d;
    eq.push_back(e);
  endtask

  task automatic clr();
    eq.delete(); lw.delete(); lts.delete(); lg.delete();
  endtask

  task automatic test_reset();
    enableChannel = 4'hF;
    load(0, 3, 30'h55);
    repeat (2) cyc();
    vec++; if (s_wr !== 1'b0)      begin errs++; $display("FAIL reset_wr: got %b want 0", s_wr); end
    vec++; if (s_rd !== 4'b0)      begin errs++; $display("FAIL reset_rd: got %b want 0000", s_rd); end
    vec++; if (s_din !== 33'b0)    begin errs++; $display("FAIL reset_din: got %h want 0", s_din); end
    vec++; if (s_g !== 4'b0)       begin errs++; $display("FAIL reset_grant: got %b want 0000", s_g); end
    vec++; if (s_busy !== 1'b0)    begin errs++; $display("FAIL reset_busy: got %b want 0", s_busy); end
    cnt[0] = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_burst_groups();
    logic [15:0] pat;
    logic [32:0] e;
    pat = 16'h1BDE;
    clr();
    noTimestamp = 1'b1; enableChannel = 4'hF;
    load(0, 10, 30'h100);
    for (int k = 0; k < 16; k++) begin
      cyc();
      vec++;
      if (s_wr !== pat[k]) begin errs++; $display("FAIL groups_wr_cycle%0d: got %b want %b", k, s_wr, pat[k]); end
    end
    for (int k = 0; k < 10; k++) ex(1'b0, 2'd0, 30'h100 + 30'(k));
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL groups_count: got %0d want %0d", lw.size(), eq.size()); end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = eq[k].hdr ? {1'b1, eq[k].ch, 30'(lts[k])} : {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e || lg[k] !== (4'b0001 << eq[k].ch)) begin
        errs++; $display("FAIL groups_word%0d: got %h/%b want %h/%b", k, lw[k], lg[k], e, 4'b0001 << eq[k].ch);
      end
    end
    vec++; if (cnt[0] != 0) begin errs++; $display("FAIL groups_reads: %0d words left want 0", cnt[0]); end
  endtask

  task automatic test_header_seq();
    logic [32:0] e;
    clr();
    noTimestamp = 1'b0; enableChannel = 4'hF;
    load(1, 1, 30'h111); load(3, 1, 30'h333);
    repeat (10) cyc();
    ex(1'b1, 2'd1, 30'h0); ex(1'b0, 2'd1, 30'h111); ex(1'b1, 2'd3, 30'h0); ex(1'b0, 2'd3, 30'h333);
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL hdr_count: got %0d want %0d", lw.size(), eq.size()); end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = eq[k].hdr ? {1'b1, eq[k].ch, 30'(lts[k])} : {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e || lg[k] !== (4'b0001 << eq[k].ch)) begin
        errs++; $display("FAIL hdr_word%0d: got %h/%b want %h/%b", k, lw[k], lg[k], e, 4'b0001 << eq[k].ch);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [32:0] e;
    clr();
    noTimestamp = 1'b1; enableChannel = 4'hF;
    for (int c = 0; c < 4; c++) load(c, 8, 30'h1000 * 30'(c + 1));
    repeat (44) cyc();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) ex(1'b0, 2'(c), 30'h1000 * 30'(c + 1) + 30'(r * 4 + k));
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL rr_count: got %0d want %0d", lw.size(), eq.size()); end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e || lg[k] !== (4'b0001 << eq[k].ch)) begin
        errs++; $display("FAIL rr_word%0d: got %h/%b want %h/%b", k, lw[k], lg[k], e, 4'b0001 << eq[k].ch);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [32:0] e;
    clr();
    noTimestamp = 1'b1; enableChannel = 4'hF;
    load(1, 4, 30'h200);
    repeat (3) cyc();
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      vec++;
      if (s_wr !== 1'b0 || s_rd !== 4'b0 || s_busy !== 1'b1) begin
        errs++; $display("FAIL stall_cycle%0d: wr=%b rd=%b busy=%b want 0/0000/1", k, s_wr, s_rd, s_busy);
      end
    end
    out_full = 1'b0;
    repeat (6) cyc();
    for (int k = 0; k < 4; k++) ex(1'b0, 2'd1, 30'h200 + 30'(k));
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL stall_count: got %0d want %0d", lw.size(), eq.size()); end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e) begin errs++; $display("FAIL stall_word%0d: got %h want %h", k, lw[k], e); end
    end
  endtask

  task automatic test_disable();
    logic [32:0] e;
    clr();
    noTimestamp = 1'b1; enableChannel = 4'hF;
    load(2, 6, 30'h300); load(3, 1, 30'h3A0);
    repeat (3) cyc();
    enableChannel = 4'b1011;
    cyc();
    vec++; if (s_wr !== 1'b0 || s_rd !== 4'b0) begin errs++; $display("FAIL dis_drop: wr=%b rd=%b want 0/0000", s_wr, s_rd); end
    cyc();
    vec++; if (s_busy !== 1'b0 || s_g !== 4'b0) begin errs++; $display("FAIL dis_idle: busy=%b grant=%b want 0/0000", s_busy, s_g); end
    repeat (2) cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      vec++; if (s_busy !== 1'b0) begin errs++; $display("FAIL dis_skip%0d: busy=%b grant=%b want idle", k, s_busy, s_g); end
    end
    enableChannel = 4'hF;
    repeat (7) cyc();
    ex(1'b0, 2'd2, 30'h300); ex(1'b0, 2'd2, 30'h301); ex(1'b0, 2'd3, 30'h3A0);
    for (int k = 2; k < 6; k++) ex(1'b0, 2'd2, 30'h300 + 30'(k));
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL dis_count: got %0d want %0d", lw.size(), eq.size()); end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e) begin errs++; $display("FAIL dis_word%0d: got %h want %h", k, lw[k], e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [32:0] e;
    clr();
    noTimestamp = 1'b0; enableChannel = 4'hF;
    load(1, 6, 30'h400);
    repeat (4) cyc();
    load(0, 2, 30'h500); load(2, 2, 30'h600);
    reset_n = 1'b0; tcnt = 0;
    #1;
    vec++;
    if (out_wr_en !== 1'b0 || ch_rd_en !== 4'b0 || out_din !== 33'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_async: wr=%b rd=%b din=%h grant=%b busy=%b want all 0", out_wr_en, ch_rd_en, out_din, grant, busy);
    end
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (30) cyc();
    ex(1'b1, 2'd1, 30'h0); ex(1'b0, 2'd1, 30'h400); ex(1'b0, 2'd1, 30'h401);
    ex(1'b1, 2'd0, 30'h0); ex(1'b0, 2'd0, 30'h500); ex(1'b0, 2'd0, 30'h501);
    ex(1'b1, 2'd1, 30'h0);
    for (int k = 2; k < 6; k++) ex(1'b0, 2'd1, 30'h400 + 30'(k));
    ex(1'b1, 2'd2, 30'h0); ex(1'b0, 2'd2, 30'h600); ex(1'b0, 2'd2, 30'h601);
    vec++; if (lw.size() != eq.size()) begin errs++; $display("FAIL rst_count: got %0d want %0d", lw.size(), eq.size()); end
    if (lw.size() > 3) begin
      vec++;
      if (lw[3][29:0] !== 30'd1) begin errs++; $display("FAIL rst_ts: got %0d want 1", lw[3][29:0]); end
    end
    for (int k = 0; k < eq.size() && k < lw.size(); k++) begin
      e = eq[k].hdr ? {1'b1, eq[k].ch, 30'(lts[k])} : {1'b0, eq[k].ch, eq[k].d};
      vec++;
      if (lw[k] !== e || lg[k] !== (4'b0001 << eq[k].ch)) begin
        errs++; $display("FAIL rst_word%0d: got %h/%b want %h/%b", k, lw[k], lg[k], e, 4'b0001 << eq[k].ch);
      end
    end
  endtask

  initial begin
    enableChannel = 4'h0; noTimestamp = 1'b1; out_full = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; head[i] = '0; end
    vec = 0; errs = 0; tcnt = 0;
    #3;
    test_reset();
    test_burst_groups();
    test_header_seq();
    test_round_robin();
    test_full_stall();
    test_disable();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/readout_arbiter.md
READOUT_ARBITER -- requirements
Module: readout_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, giving the maximum data words written per grant (legal range 1..255).
REQ-002 The block SHALL have port clk40, input, 1 bit: the 40 MHz main clock; all logic is on this single clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 The block SHALL have port enableChannel, input, 4 bits: per-channel arbitration enable.
REQ-005 The block SHALL have port noTimestamp, input, 1 bit: 1 suppresses header words.
REQ-006 The block SHALL have port ch_empty, input, 4 bits: empty flags of the four first-stage FWFT FIFOs.
REQ-007 The block SHALL have ports ch1_data..ch4_data, input, 32 bits each: FWFT FIFO heads; only bits [29:0] are used.
REQ-008 The block SHALL have port ch_rd_en, output, 4 bits: one-hot FIFO read pulse.
REQ-009 The block SHALL have port out_full, input, 1 bit: output FIFO full.
REQ-010 The block SHALL have port out_wr_en, output, 1 bit: output FIFO write strobe.
REQ-011 The block SHALL have port out_din, output, 33 bits: merged output word.
REQ-012 The block SHALL have port grant, output, 4 bits: one-hot channel currently owned (0 when idle).
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in states HDR and BURST.

Function
REQ-014 A channel SHALL be eligible when enableChannel[i]=1 and ch_empty[i]=0.
REQ-015 The FSM SHALL have states IDLE, HDR and BURST.
REQ-016 In IDLE with at least one channel eligible, the FSM SHALL grant the first eligible channel searching upward (wrapping 3->0) from last_grant+1, latch last_grant, and next enter HDR if noTimestamp=0, else BURST.
REQ-017 noTimestamp SHALL be sampled only at grant; changes mid-grant take effect at the next grant.
REQ-018 In HDR, when out_full=0, the block SHALL write header {1'b1, ch_id[1:0], ts[29:0]} and enter BURST; when out_full=1 it SHALL stay in HDR with no write.
REQ-019 ts SHALL be a free-running 30-bit counter incrementing every clk40 cycle, wrapping 2^30-1 -> 0; the header carries the value at the write cycle.
REQ-020 In BURST, when out_full=0, ch_empty[g]=0 and enableChannel[g]=1, the block SHALL in the same cycle assert out_wr_en, ch_rd_en[g] and out_din = {1'b0, ch_id[1:0], ch_data_g[29:0]}, and increment the 8-bit burst counter.
REQ-021 The FSM SHALL return to IDLE on the cycle after the MAX_BURST-th data write.
REQ-022 In BURST, if ch_empty[g]=1 or enableChannel[g]=0, the FSM SHALL return to IDLE with no write that cycle; priority: disable/empty over full.
REQ-023 In BURST with out_full=1 and the channel still eligible, the block SHALL stall (no write, no read, counter held).
REQ-024 ch_rd_en SHALL never assert without out_wr_en in the same cycle, never for an empty channel, and at most one bit at a time.
REQ-025 IDLE SHALL last at least one cycle between grants; a header with zero data words SHALL be permitted when the channel empties after HDR.
REQ-026 The burst counter SHALL clear on every entry to IDLE.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force: state IDLE, last_grant=3 (channel 0 first), ts=0, burst counter=0, out_wr_en=0, ch_rd_en=0, out_din=0, grant=0, busy=0.
REQ-028 Reset mid-burst SHALL abort the grant with no further writes or reads; after reset_n rises, arbitration restarts from channel 0.

Verification
REQ-029 noTimestamp=1, all enabled, ch0 holds 10 words, others empty -> writes in groups of 4,4,2 with a one-cycle IDLE gap between groups, all tagged ch_id=0, 10 ch_rd_en[0] pulses.
REQ-030 noTimestamp=0, ch1 and ch3 each hold 1 word -> sequence: header(ch1), data(ch1), header(ch3), data(ch3); each header bit32=1.
REQ-031 All four channels continuously non-empty -> grant order 0,1,2,3,0 repeating; each grant exactly MAX_BURST data words.
REQ-032 out_full held high for 5 cycles mid-burst -> no out_wr_en/ch_rd_en during those cycles, burst resumes, total word count unchanged.
REQ-033 enableChannel[2] dropped during a ch2 burst -> no write that cycle, IDLE next, ch2 skipped until re-enabled.
REQ-034 reset_n pulsed low during BURST -> all outputs 0 asynchronously, ts restarts at 0, first post-reset grant goes to channel 0.
